// File: rtl/sd_track_sched_if.sv
// Requester, command and completion signals between the track scheduler,
// the playback/record FIFOs and the SD block engine.
interface sd_track_sched_if #(
    parameter int CHANNELS   = 8,
    parameter int ADDR_WIDTH = 32
);
    localparam int CW = $clog2(CHANNELS);

    logic                  enable;
    logic                  rewind;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [CHANNELS-1:0]   rd_req;
    logic                  wr_req;
    logic [CW-1:0]         wr_ch;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [CW-1:0]         cmd_ch;
    logic                  cmd_done;
    logic [CHANNELS-1:0]   grant_done;
    logic                  wr_done;
    logic                  busy;

    // master: the scheduler, which issues block commands
    modport master (
        input  enable, rewind, base_addr, rd_req, wr_req, wr_ch, cmd_ready, cmd_done,
        output cmd_valid, cmd_write, cmd_addr, cmd_ch, grant_done, wr_done, busy
    );

    modport slave (
        output enable, rewind, base_addr, rd_req, wr_req, wr_ch, cmd_ready, cmd_done,
        input  cmd_valid, cmd_write, cmd_addr, cmd_ch, grant_done, wr_done, busy
    );
endinterface

// File: rtl/sd_track_scheduler.sv
// Shares one SD block engine between per-track read FIFOs and the record FIFO;
// one command in flight, per-track block position counters build the card address.
module sd_track_scheduler #(
    parameter int CHANNELS    = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int TRACK_SHIFT = 25,
    parameter int BLOCK_SHIFT = 9
) (
    input  logic                clk_i,
    input  logic                rst_i,
    sd_track_sched_if.master    bus
);
    localparam int CW = $clog2(CHANNELS);
    localparam int PW = TRACK_SHIFT - BLOCK_SHIFT;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    state_e                       state_q, state_d;
    logic [CHANNELS-1:0][PW-1:0]  pos_q, pos_d;
    logic [CW-1:0]                rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]                cmd_ch_q, cmd_ch_d;
    logic                         cmd_write_q, cmd_write_d;
    logic [ADDR_WIDTH-1:0]        cmd_addr_q, cmd_addr_d;
    logic                         cmd_valid_q, cmd_valid_d;
    logic [CHANNELS-1:0]          grant_done_q, grant_done_d;
    logic                         wr_done_q, wr_done_d;
    logic                         busy_q, busy_d;

    logic                         rd_hit;
    logic [CW-1:0]                rd_sel;
    logic [2*CHANNELS-1:0]        req_rot;
    logic [CW:0]                  rd_sum;

    // Rotate the request vector so bit 0 is rr_ptr; the first set bit wins.
    always_comb begin
        rd_hit  = 1'b0;
        rd_sel  = '0;
        rd_sum  = '0;
        req_rot = {bus.rd_req, bus.rd_req} >> rr_ptr_q;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!rd_hit && req_rot[k]) begin
                rd_hit = 1'b1;
                rd_sum = {1'b0, rr_ptr_q} + (CW+1)'(k);
                rd_sel = (rd_sum >= (CW+1)'(CHANNELS)) ? CW'(rd_sum - (CW+1)'(CHANNELS))
                                                       : CW'(rd_sum);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        rr_ptr_d     = rr_ptr_q;
        cmd_ch_d     = cmd_ch_q;
        cmd_write_d  = cmd_write_q;
        cmd_addr_d   = cmd_addr_q;
        grant_done_d = '0;
        wr_done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.enable && (bus.wr_req || rd_hit)) begin
                    cmd_write_d = bus.wr_req;
                    cmd_ch_d    = bus.wr_req ? bus.wr_ch : rd_sel;
                    cmd_addr_d  = bus.base_addr
                                + (ADDR_WIDTH'(cmd_ch_d) << TRACK_SHIFT)
                                + (ADDR_WIDTH'(pos_q[cmd_ch_d]) << BLOCK_SHIFT);
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.cmd_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.cmd_done) begin
                    pos_d[cmd_ch_q] = pos_q[cmd_ch_q] + 1'b1;
                    if (cmd_write_q) begin
                        wr_done_d = 1'b1;
                    end else begin
                        grant_done_d[cmd_ch_q] = 1'b1;
                        rr_ptr_d = (cmd_ch_q == CW'(CHANNELS-1)) ? '0 : cmd_ch_q + 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Rewind wins over a same-cycle completion increment.
        if (bus.rewind) pos_d = '0;
        cmd_valid_d = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            pos_q        <= '0;
            rr_ptr_q     <= '0;
            cmd_ch_q     <= '0;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_valid_q  <= 1'b0;
            grant_done_q <= '0;
            wr_done_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            rr_ptr_q     <= rr_ptr_d;
            cmd_ch_q     <= cmd_ch_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_valid_q  <= cmd_valid_d;
            grant_done_q <= grant_done_d;
            wr_done_q    <= wr_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_write  = cmd_write_q;
    assign bus.cmd_addr   = cmd_addr_q;
    assign bus.cmd_ch     = cmd_ch_q;
    assign bus.grant_done = grant_done_q;
    assign bus.wr_done    = wr_done_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sd_track_scheduler.sv
// Directed bench for sd_track_scheduler; a shadow instance with a 2-bit
// position counter shares all inputs so counter wrap is reachable quickly.
module tb_sd_track_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   acc_cnt = 0;

    always #5 clk = ~clk;

    sd_track_sched_if #(.CHANNELS(8), .ADDR_WIDTH(32)) ifc ();
    sd_track_sched_if #(.CHANNELS(8), .ADDR_WIDTH(32)) ifw ();

    sd_track_scheduler #(.CHANNELS(8), .ADDR_WIDTH(32), .TRACK_SHIFT(25), .BLOCK_SHIFT(9))
        dut (.clk_i(clk), .rst_i(rst), .bus(ifc.master));

    sd_track_scheduler #(.CHANNELS(8), .ADDR_WIDTH(32), .TRACK_SHIFT(11), .BLOCK_SHIFT(9))
        u_wrap (.clk_i(clk), .rst_i(rst), .bus(ifw.master));

    assign ifw.enable    = ifc.enable;
    assign ifw.rewind    = ifc.rewind;
    assign ifw.base_addr = ifc.base_addr;
    assign ifw.rd_req    = ifc.rd_req;
    assign ifw.wr_req    = ifc.wr_req;
    assign ifw.wr_ch     = ifc.wr_ch;
    assign ifw.cmd_ready = ifc.cmd_ready;
    assign ifw.cmd_done  = ifc.cmd_done;

    always @(posedge clk) if (ifc.cmd_valid && ifc.cmd_ready) acc_cnt <= acc_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!ifc.cmd_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Wait for the grant, check it, accept it, complete it 3 cycles later.
    task automatic serve(input string tag, input logic ew, input int ech,
                         input logic [31:0] eaddr, input logic rew);
        wait_valid();
        chk({tag, "_vld"},  64'(ifc.cmd_valid), 64'd1);
        chk({tag, "_wr"},   64'(ifc.cmd_write), 64'(ew));
        chk({tag, "_ch"},   64'(ifc.cmd_ch),    64'(ech));
        chk({tag, "_addr"}, 64'(ifc.cmd_addr),  64'(eaddr));
        ifc.cmd_ready = 1'b1;
        tick();
        ifc.cmd_ready = 1'b0;
        chk({tag, "_acc"}, 64'(ifc.cmd_valid), 64'd0);
        tick();
        tick();
        ifc.cmd_done = 1'b1;
        ifc.rewind   = rew;
        tick();
        ifc.cmd_done = 1'b0;
        ifc.rewind   = 1'b0;
        if (ew) begin
            chk({tag, "_wdone"}, 64'(ifc.wr_done),    64'd1);
            chk({tag, "_gdone"}, 64'(ifc.grant_done), 64'd0);
        end else begin
            chk({tag, "_gdone"}, 64'(ifc.grant_done), 64'(8'(1) << ech));
            chk({tag, "_wdone"}, 64'(ifc.wr_done),    64'd0);
        end
    endtask

    task automatic rewind_pulse();
        ifc.rewind = 1'b1;
        tick();
        ifc.rewind = 1'b0;
    endtask

    initial begin
        int a0;
        ifc.enable = 1'b1; ifc.rewind = 1'b0; ifc.base_addr = '0;
        ifc.rd_req = '0;   ifc.wr_req = 1'b0; ifc.wr_ch = '0;
        ifc.cmd_ready = 1'b0; ifc.cmd_done = 1'b0;
        tick(); tick();
        rst = 1'b0;

        chk("rst_valid", 64'(ifc.cmd_valid),  64'd0);
        chk("rst_write", 64'(ifc.cmd_write),  64'd0);
        chk("rst_addr",  64'(ifc.cmd_addr),   64'd0);
        chk("rst_ch",    64'(ifc.cmd_ch),     64'd0);
        chk("rst_gdone", 64'(ifc.grant_done), 64'd0);
        chk("rst_wdone", 64'(ifc.wr_done),    64'd0);
        chk("rst_busy",  64'(ifc.busy),       64'd0);

        // single read on ch2, one-cycle grant latency
        ifc.rd_req = 8'b0000_0100;
        tick();
        chk("rd1_lat", 64'(ifc.cmd_valid), 64'd1);
        chk("rd1_busy", 64'(ifc.busy), 64'd1);
        serve("rd1", 1'b0, 2, 32'h0400_0000, 1'b0);
        ifc.rd_req = '0;
        tick();
        chk("rd1_pulse", 64'(ifc.grant_done), 64'd0);
        chk("rd1_idle",  64'(ifc.busy), 64'd0);
        ifc.rd_req = 8'b0000_0100;
        tick();
        serve("rd1b", 1'b0, 2, 32'h0400_0200, 1'b0);
        ifc.rd_req = '0;

        // reset while waiting for completion: no done pulse
        tick();
        ifc.rd_req = 8'h01;
        tick();
        ifc.cmd_ready = 1'b1;
        tick();
        ifc.cmd_ready = 1'b0;
        ifc.rd_req = '0;
        rst = 1'b1;
        ifc.cmd_done = 1'b1;
        tick();
        ifc.cmd_done = 1'b0;
        rst = 1'b0;
        chk("rstmid_gdone", 64'(ifc.grant_done), 64'd0);
        chk("rstmid_busy",  64'(ifc.busy), 64'd0);
        chk("rstmid_valid", 64'(ifc.cmd_valid), 64'd0);

        // round robin from rr_ptr=0, all tracks requesting
        ifc.rd_req = 8'hFF;
        for (int i = 0; i < 8; i++)
            serve($sformatf("rr%0d", i), 1'b0, i, 32'(i) << 25, 1'b0);
        serve("rr8", 1'b0, 0, 32'h0000_0200, 1'b0);
        serve("rr9", 1'b0, 1, 32'h0200_0200, 1'b0);
        ifc.rd_req = '0;

        // write priority over reads; rr_ptr (=2) untouched by the write
        ifc.base_addr = 32'h1000_0000;
        ifc.rd_req = 8'hFF; ifc.wr_req = 1'b1; ifc.wr_ch = 3'd5;
        serve("wr", 1'b1, 5, 32'h1A00_0200, 1'b0);
        ifc.wr_req = 1'b0;
        serve("wr_rd2", 1'b0, 2, 32'h1400_0200, 1'b0);
        serve("wr_rd3", 1'b0, 3, 32'h1600_0200, 1'b0);
        ifc.rd_req = '0;

        // backpressure: held stable for 10 cycles, one acceptance
        ifc.rd_req = 8'h40;
        tick();
        ifc.rd_req = '0;
        a0 = acc_cnt;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(ifc.cmd_valid), 64'd1);
            chk("bp_addr",  64'(ifc.cmd_addr),  64'h1C00_0200);
            chk("bp_ch",    64'(ifc.cmd_ch),    64'd6);
            tick();
        end
        serve("bp", 1'b0, 6, 32'h1C00_0200, 1'b0);
        tick(); tick();
        chk("bp_accepts", 64'(acc_cnt - a0), 64'd1);
        chk("bp_novalid", 64'(ifc.cmd_valid), 64'd0);

        // rewind colliding with a ch3 completion at pos 7
        rewind_pulse();
        ifc.rd_req = 8'h08;
        for (int k = 0; k < 7; k++)
            serve($sformatf("rw%0d", k), 1'b0, 3, 32'h1600_0000 + (32'(k) << 9), 1'b0);
        serve("rw_col", 1'b0, 3, 32'h1600_0E00, 1'b1);
        serve("rw_after", 1'b0, 3, 32'h1600_0000, 1'b0);
        ifc.rd_req = '0;

        // stray cmd_done in IDLE is ignored
        tick();
        ifc.cmd_done = 1'b1;
        tick();
        ifc.cmd_done = 1'b0;
        chk("stray_gdone", 64'(ifc.grant_done), 64'd0);
        chk("stray_wdone", 64'(ifc.wr_done), 64'd0);
        chk("stray_busy",  64'(ifc.busy), 64'd0);
        ifc.rd_req = 8'h08;
        tick();
        serve("stray_pos", 1'b0, 3, 32'h1600_0200, 1'b0);
        ifc.rd_req = '0;

        // counter wrap, seen on the 2-bit shadow instance
        rewind_pulse();
        ifc.rd_req = 8'h01;
        for (int k = 0; k < 5; k++) begin
            wait_valid();
            chk($sformatf("wrap%0d_addr", k), 64'(ifw.cmd_addr), 64'(32'h1000_0000 + (32'(k % 4) << 9)));
            serve($sformatf("wrap%0d", k), 1'b0, 0, 32'h1000_0000 + (32'(k) << 9), 1'b0);
        end
        ifc.rd_req = '0;

        // enable dropped mid-command: completes, then no new grants
        tick();
        ifc.rd_req = 8'h01;
        tick();
        chk("en_valid", 64'(ifc.cmd_valid), 64'd1);
        chk("en_addr",  64'(ifc.cmd_addr),  64'h1000_0A00);
        ifc.cmd_ready = 1'b1;
        tick();
        ifc.cmd_ready = 1'b0;
        ifc.enable = 1'b0;
        tick();
        ifc.cmd_done = 1'b1;
        tick();
        ifc.cmd_done = 1'b0;
        chk("en_gdone", 64'(ifc.grant_done), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("en_off_valid", 64'(ifc.cmd_valid), 64'd0);
            chk("en_off_busy",  64'(ifc.busy), 64'd0);
        end
        ifc.enable = 1'b1;
        tick();
        chk("en_on_valid", 64'(ifc.cmd_valid), 64'd1);
        serve("en_on", 1'b0, 0, 32'h1000_0C00, 1'b0);
        ifc.rd_req = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sd_track_scheduler.md
# sd_track_scheduler

Arbitrates the single SD-card block engine among the playback track FIFOs (one read requester per channel) and the record FIFO (one write requester). It sits between the per-track sample buffers and the SD block read/write engine inside the store/load path, in the 100 MHz domain. For every granted request it computes the card byte address from a per-track block position counter and issues exactly one block command. It then waits for completion and advances that track's position.

## Interface
- CHANNELS, 8: number of tracks; reader count and counter count.
- ADDR_WIDTH, 32: card byte-address width.
- TRACK_SHIFT, 25: log2 of the byte span reserved per track.
- BLOCK_SHIFT, 9: log2 of block size in bytes (512).

- clk  in  1  system clock (100 MHz domain).
- rst  in  1  synchronous, active-high reset.
- enable  in  1  high: arbitration allowed; low: no new grants, any in-flight command still completes.
- rewind  in  1  one-cycle pulse; clears all track position counters.
- base_addr  in  ADDR_WIDTH  project base byte address; sampled at grant.
- rd_req  in  CHANNELS  level per track; playback FIFO below its low watermark.
- wr_req  in  1  level; record FIFO holds at least one block.
- wr_ch  in  $clog2(CHANNELS)  track being recorded; sampled at grant.
- cmd_valid  out  1  command offered to the SD engine.
- cmd_ready  in  1  SD engine accepts the command.
- cmd_write  out  1  1 = block write, 0 = block read.
- cmd_addr  out  ADDR_WIDTH  card byte address of the block.
- cmd_ch  out  $clog2(CHANNELS)  track served; steers the SD engine's data to or from the right FIFO.
- cmd_done  in  1  one-cycle pulse; block transfer finished.
- grant_done  out  CHANNELS  one-cycle pulse on bit cmd_ch when a read completes.
- wr_done  out  1  one-cycle pulse when a write completes.
- busy  out  1  high in ISSUE and WAIT.

## Operation
- **State machine:** IDLE -> ISSUE -> WAIT -> IDLE.
- **IDLE arbitration.** Arbitration runs when enable=1 and (wr_req | rd_req) is non-zero.
  - Write has fixed priority over all reads.
  - Reads are granted round-robin: the first set rd_req bit at or after rr_ptr, searching upward and wrapping.
  - The chosen request is latched into cmd_write, cmd_ch and cmd_addr, and the FSM goes to ISSUE.
- **Address:** cmd_addr = base_addr + (cmd_ch << TRACK_SHIFT) + (pos[cmd_ch] << BLOCK_SHIFT), computed modulo 2^ADDR_WIDTH.
- **Position counters:** pos[i] is TRACK_SHIFT-BLOCK_SHIFT bits wide (16 bits by default).
  - It wraps from all-ones to 0; the wrap is silent.
  - Read and write completions both advance pos of the track served.
- **ISSUE:**
  - cmd_valid=1 and all cmd_* outputs are held stable.
  - The handshake completes in the cycle cmd_valid & cmd_ready; the FSM then goes to WAIT.
- **WAIT:**
  - On cmd_done: pos[cmd_ch] increments by 1, grant_done[cmd_ch] or wr_done pulses, and the FSM returns to IDLE.
  - After a read grant completes, rr_ptr = cmd_ch+1 (wrapping). A write leaves rr_ptr unchanged.
- **cmd_done outside WAIT:** ignored.
- **rewind:**
  - Clears every pos to 0 in any state.
  - A rewind in the same cycle as the cmd_done increment takes precedence: pos ends at 0.
  - An in-flight or already-latched command is not modified or cancelled; its done pulses are still produced.
- **enable low:** takes effect only in IDLE. ISSUE and WAIT always run to completion.
- **Deasserted requests:** rd_req or wr_req deasserting after the grant has no effect on the in-flight command.

## Timing
- **Reset values:**
  - FSM in IDLE, all pos = 0, rr_ptr = 0.
  - cmd_valid = 0, cmd_write = 0, cmd_addr = 0, cmd_ch = 0.
  - grant_done = 0, wr_done = 0, busy = 0.
- **Reset mid-operation:** abandons the command with no done pulse. Resetting the SD engine is its owner's responsibility.
- **Latency:**
  - A request sampled in IDLE at cycle N gives cmd_valid=1 at N+1.
  - cmd_ready at cycle M gives cmd_valid=0 at M+1.
  - cmd_done at cycle K gives the done pulse and the pos update visible at K+1, with the FSM in IDLE at K+1.
  - The earliest next arbitration is K+1, so at most one command is outstanding.
- **Outputs:** all are registered; there is no combinational path from any input to any output.

## Test plan
- **Single read:**
  - Stimulus: reset, base_addr=0x0000_0000, rd_req=0b0000_0100, cmd_ready=1.
  - Response: cmd_valid 1 cycle after request; cmd_ch=2, cmd_write=0, cmd_addr=0x0400_0000.
  - Then cmd_done: grant_done=0b100 for 1 cycle; the next grant on ch2 has cmd_addr=0x0400_0200.
- **Round-robin:**
  - Stimulus: rd_req=0xFF held, cmd_ready=1, cmd_done 3 cycles after each accept.
  - Response: grants in order ch0,1,2,…,7,0; each track's pos = 1 after the first lap.
- **Write priority:**
  - Stimulus: rd_req=0xFF, wr_req=1, wr_ch=5.
  - Response: first grant has cmd_write=1, cmd_ch=5, cmd_addr=base+0x0A00_0000.
  - After wr_done, the next read grant starts from the unchanged rr_ptr.
- **Backpressure:**
  - Stimulus: cmd_ready low for 10 cycles while in ISSUE.
  - Response: cmd_valid, cmd_addr and cmd_ch stable all 10 cycles; exactly one acceptance.
- **Rewind collision:**
  - Stimulus: pos[3]=7, with rewind and cmd_done for ch3 in the same cycle.
  - Response: grant_done[3] pulses, pos[3]=0, and the next ch3 address is base+0x0600_0000.
- **Wrap and enable:**
  - Stimulus: force pos[0]=0xFFFF, then complete one ch0 read.
  - Response: pos[0]=0.
  - Stimulus: drop enable during WAIT.
  - Response: the command completes, then no cmd_valid while enable=0 despite rd_req≠0.
